// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions used by both the write- and read-side pointer
// handlers: default geometry and Gray/binary conversion helpers for the
// default pointer width (FifoWidth+1 bits).
package fifo_pkg;

    localparam int unsigned FifoWidth = 4;
    localparam int unsigned FifoDepth = 2 ** FifoWidth;

    typedef logic [FifoWidth:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    // XOR prefix from the MSB down.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        for (int unsigned i = 0; i <= FifoWidth; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Parameterised combinational Gray-to-binary converter.
// Ports:
//   gray  in   width  Gray-coded value
//   bin   out  width  binary equivalent
module gray2bin #(
    parameter int unsigned width = 5
) (
    input  logic [width-1:0] gray,
    output logic [width-1:0] bin
);

    // Each binary bit is the XOR of its own Gray bit and every bit above it.
    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < width; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_handle.sv
// Write-domain pointer and flag controller for the asynchronous FIFO.
// Holds the binary write address and the registered Gray write pointer that
// goes to the read domain, derives full from the synchronised Gray read
// pointer, and keeps a registered level estimate, almost_full and a sticky
// overflow flag.
// Ports:
//   clk          in   1        write-domain clock
//   reset        in   1        synchronous active-high reset
//   w_en         in   1        write request from client
//   rptr_sync    in   width+1  Gray read pointer synchronised into clk domain
//   ovf_clr      in   1        clears sticky overflow
//   wptr         out  width+1  registered Gray write pointer
//   w_addr       out  width    RAM write address
//   w_accept     out  1        RAM write enable
//   full         out  1        FIFO full as seen from the write domain
//   almost_full  out  1        registered, w_level >= AF_THRESH
//   w_level      out  width+1  registered occupancy estimate
//   overflow     out  1        sticky, write attempted while full
module wptr_handle
    import fifo_pkg::*;
#(
    parameter int unsigned width     = FifoWidth,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_en,
    input  logic [width:0]   rptr_sync,
    input  logic             ovf_clr,
    output logic [width:0]   wptr,
    output logic [width-1:0] w_addr,
    output logic             w_accept,
    output logic             full,
    output logic             almost_full,
    output logic [width:0]   w_level,
    output logic             overflow
);

    localparam logic [width:0] AfThresh = (width + 1)'(AF_THRESH);

    logic [width:0] addr_q, addr_d;
    logic [width:0] gray_q, gray_d;
    logic [width:0] level_q, level_d;
    logic           af_q, af_d;
    logic           ovf_q, ovf_d;
    logic [width:0] rbin;
    logic [width:0] full_cmp;

    gray2bin #(
        .width(width + 1)
    ) u_rbin (
        .gray(rptr_sync),
        .bin (rbin)
    );

    // Full when the write pointer is exactly one lap ahead: in Gray code that
    // is the read pointer with its top two bits inverted.
    assign full_cmp = {~rptr_sync[width:width-1], rptr_sync[width-2:0]};
    assign full     = (gray_q == full_cmp);

    // No RAM write while the block is held in reset.
    assign w_accept = w_en & ~full & ~reset;

    always_comb begin
        addr_d  = addr_q + {{width{1'b0}}, w_accept};
        gray_d  = (addr_d >> 1) ^ addr_d;
        level_d = addr_d - rbin;
        af_d    = (level_d >= AfThresh);
        // Set wins over a same-cycle clear.
        ovf_d   = (w_en & full) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            gray_q  <= '0;
            level_q <= '0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wptr        = gray_q;
    assign w_addr      = addr_q[width-1:0];
    assign w_level     = level_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_handle.sv
// Directed bench for wptr_handle (width=4, AF_THRESH=12).
module tb_wptr_handle;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       w_en;
    logic [4:0] rptr_sync;
    logic       ovf_clr;
    logic [4:0] wptr;
    logic [3:0] w_addr;
    logic       w_accept;
    logic       full;
    logic       almost_full;
    logic [4:0] w_level;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    wptr_handle #(
        .width    (4),
        .AF_THRESH(12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .w_en       (w_en),
        .rptr_sync  (rptr_sync),
        .ovf_clr    (ovf_clr),
        .wptr       (wptr),
        .w_addr     (w_addr),
        .w_accept   (w_accept),
        .full       (full),
        .almost_full(almost_full),
        .w_level    (w_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] a5;
        reset     = 1'b1;
        w_en      = 1'b0;
        rptr_sync = 5'b00000;
        ovf_clr   = 1'b0;
        step();
        step();
        check("rst_wptr", wptr, 0);
        check("rst_waddr", w_addr, 0);
        check("rst_level", w_level, 0);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_full", full, 0);
        reset = 1'b0;

        // 1. Fill 16 entries with the reader parked at 0.
        w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("fill_waddr", w_addr, i);
            check("fill_acc", w_accept, 1);
            step();
            check("fill_level", w_level, i + 1);
            check("fill_af", almost_full, (i + 1 >= 12) ? 1 : 0);
        end
        check("fill_wptr", wptr, 5'b11000);
        check("fill_full", full, 1);

        // 2. Writes while full are dropped and latch overflow.
        for (int i = 0; i < 3; i++) begin
            check("ovf_acc", w_accept, 0);
            step();
            check("ovf_wptr", wptr, 5'b11000);
            check("ovf_flag", overflow, 1);
        end
        ovf_clr = 1'b1;  // set and clear together: set wins
        step();
        check("ovf_setwins", overflow, 1);
        w_en = 1'b0;
        step();
        check("ovf_clr", overflow, 0);
        ovf_clr = 1'b0;
        check("ovf_level", w_level, 16);

        // 3. Reader moves to 3: full drops at once, three slots open up.
        rptr_sync = 5'b00010;
        #1;
        check("drain_full", full, 0);
        step();
        check("drain_level", w_level, 13);
        check("drain_af", almost_full, 1);
        w_en = 1'b1;
        step();
        check("drain_acc_level", w_level, 14);
        step();
        step();
        check("drain_level16", w_level, 16);
        check("drain_wptr", wptr, 5'b11010);
        check("drain_refull", full, 1);

        // 4. Wrap: keep the reader 10 behind while writing past address 31.
        for (int a = 19; a < 36; a++) begin
            a5 = 5'(a - 10);
            rptr_sync = bin2gray(a5);
            #1;
            check("wrap_full", full, 0);
            check("wrap_waddr", w_addr, a % 16);
            if (a == 31) check("wrap_wptr31", wptr, 5'b10000);
            step();
            check("wrap_level", w_level, 11);
            if (a == 31) begin
                check("wrap_wptr0", wptr, 5'b00000);
                check("wrap_waddr0", w_addr, 0);
            end
        end
        check("wrap_af", almost_full, 0);

        // 5. Threshold: level 11 -> write -> 12, then reader advance -> 11.
        step();
        check("thr_level12", w_level, 12);
        check("thr_af_rise", almost_full, 1);
        w_en = 1'b0;
        rptr_sync = 5'b10111;  // gray(26)
        step();
        check("thr_level11", w_level, 11);
        check("thr_af_fall", almost_full, 0);

        // 6. Reset at level 7 with a write pending.
        rptr_sync = 5'b10001;  // gray(30); addr is 5
        step();
        check("mid_level7", w_level, 7);
        w_en  = 1'b1;
        reset = 1'b1;
        #1;
        check("mid_noacc", w_accept, 0);
        step();
        check("mid_wptr", wptr, 0);
        check("mid_waddr", w_addr, 0);
        check("mid_level", w_level, 0);
        check("mid_ovf", overflow, 0);
        check("mid_af", almost_full, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
